// File: rtl/time_of_day_counter.sv
// time_of_day_counter
// Binary hours/minutes/seconds chain advanced by a one-cycle 1 Hz strobe.
// Supports direct load, per-field set strobes, and a registered DAY_UP pulse
// on the 23:59:59 -> 00:00:00 rollover that feeds the day-of-week counter.
// Per-cycle priority: Clr > LD > SetHour/SetMin > Tick; losers are discarded.

module time_of_day_counter (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       LD,
  input  logic [4:0] LD_HOUR,
  input  logic [5:0] LD_MIN,
  input  logic [5:0] LD_SEC,
  input  logic       SetHour,
  input  logic       SetMin,
  output logic [4:0] HOUR,
  output logic [5:0] MIN,
  output logic [5:0] SEC,
  output logic       DAY_UP
);

  localparam logic [4:0] HOUR_LAST = 5'd23;
  localparam logic [5:0] MIN_LAST  = 6'd59;
  localparam logic [5:0] SEC_LAST  = 6'd59;

  logic       sec_last;
  logic       min_last;
  logic       hour_last;
  logic [4:0] hour_inc;
  logic [5:0] min_inc;
  logic [5:0] sec_inc;
  logic [4:0] ld_hour_ok;
  logic [5:0] ld_min_ok;
  logic [5:0] ld_sec_ok;

  // Terminal-value detection and compare-and-wrap increments for each field.
  always_comb begin
    sec_last  = (SEC  == SEC_LAST);
    min_last  = (MIN  == MIN_LAST);
    hour_last = (HOUR == HOUR_LAST);
    sec_inc   = sec_last  ? 6'd0 : SEC  + 6'd1;
    min_inc   = min_last  ? 6'd0 : MIN  + 6'd1;
    hour_inc  = hour_last ? 5'd0 : HOUR + 5'd1;
  end

  // Load values are range-checked per field; an out-of-range field loads as 0.
  always_comb begin
    ld_hour_ok = (LD_HOUR > HOUR_LAST) ? 5'd0 : LD_HOUR;
    ld_min_ok  = (LD_MIN  > MIN_LAST)  ? 6'd0 : LD_MIN;
    ld_sec_ok  = (LD_SEC  > SEC_LAST)  ? 6'd0 : LD_SEC;
  end

  // Time-of-day registers and DAY_UP, updated under the fixed event priority.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      HOUR   <= 5'd0;
      MIN    <= 6'd0;
      SEC    <= 6'd0;
      DAY_UP <= 1'b0;
    end else if (LD) begin
      HOUR   <= ld_hour_ok;
      MIN    <= ld_min_ok;
      SEC    <= ld_sec_ok;
      DAY_UP <= 1'b0;
    end else if (SetHour || SetMin) begin
      // Set strobes never carry into the next field and never signal a new day.
      if (SetHour) begin
        HOUR <= hour_inc;
      end
      if (SetMin) begin
        MIN <= min_inc;
        SEC <= 6'd0;
      end
      DAY_UP <= 1'b0;
    end else if (Tick) begin
      SEC <= sec_inc;
      if (sec_last) begin
        MIN <= min_inc;
        if (min_last) begin
          HOUR <= hour_inc;
        end
      end
      DAY_UP <= sec_last && min_last && hour_last;
    end else begin
      DAY_UP <= 1'b0;
    end
  end

endmodule
